// File: rtl/bram_stream_reader_pkg.sv
// Shared accelerator-wrapper definitions for bram_stream_reader: FSM state
// width and encodings.
package bram_stream_reader_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bram_stream_reader_skid_buf.sv
// stream_skid_buf: 2-entry valid/ready buffer; outputs come straight from
// registers, so out_valid/out_data never depend combinationally on out_ready.
module stream_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps occupancy; the new word goes behind any older one.
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams cmd_len words from an external BRAM read port
// starting at cmd_addr. Define BRAM_READER_LAST_EN to add the ms_last output.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 72,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LOG_DEPTH = 9
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [LOG_DEPTH-1:0] cmd_addr,
  input  logic [LOG_DEPTH:0]   cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [LOG_DEPTH-1:0] bram_addr,
  input  logic [WIDTH-1:0]     bram_rdata,
  output logic [WIDTH-1:0]     ms_data,
  output logic                 ms_valid,
  input  logic                 ms_ready,
  output logic                 busy,
  output logic                 done
`ifdef BRAM_READER_LAST_EN
  ,
  output logic                 ms_last
`endif
);

  localparam logic [LOG_DEPTH-1:0] ADDR_LAST = LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_DEPTH-1:0] ADDR_ONE  = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]   LEN_ONE   = (LOG_DEPTH + 1)'(1);

  rd_state_e            state_q, state_d;
  logic [LOG_DEPTH-1:0] addr_q, addr_d;
  logic [LOG_DEPTH:0]   rem_q, rem_d;
  logic [LOG_DEPTH:0]   out_rem_q, out_rem_d;
  logic                 rvalid_q, rvalid_d;
  logic                 done_q, done_d;
  logic                 buf_in_ready;
  logic                 pop, room_next, deliver;

  assign cmd_ready = resetn && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign bram_addr = addr_q;
  assign pop       = ms_valid && ms_ready;

  // The address is only advanced once the word it selects is sure to find a
  // free buffer slot on the cycle its data returns; otherwise the address is
  // held, which simply re-reads the same location.
  assign room_next = pop || (buf_in_ready && !(ms_valid && rvalid_q));
  assign deliver   = (state_q == ST_READ) && (rem_q != '0) && room_next;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    out_rem_d = pop ? out_rem_q - LEN_ONE : out_rem_q;
    rvalid_d  = deliver;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          rem_d     = cmd_len;
          out_rem_d = cmd_len;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (deliver) begin
          addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
          rem_d  = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_rem_q == LEN_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      out_rem_q <= '0;
      rvalid_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      out_rem_q <= out_rem_d;
      rvalid_q  <= rvalid_d;
      done_q    <= done_d;
    end
  end

  stream_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (rvalid_q),
    .in_ready  (buf_in_ready),
    .in_data   (bram_rdata),
    .out_valid (ms_valid),
    .out_ready (ms_ready),
    .out_data  (ms_data)
  );

`ifdef BRAM_READER_LAST_EN
  assign ms_last = ms_valid && (out_rem_q == LEN_ONE);
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a 1-cycle-latency
// BRAM model preloaded with mem[i] = i.
module tb_bram_stream_reader;

  localparam int unsigned WIDTH     = 72;
  localparam int unsigned DEPTH     = 512;
  localparam int unsigned LOG_DEPTH = 9;
  localparam int unsigned NONE      = 99999;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [LOG_DEPTH-1:0] cmd_addr;
  logic [LOG_DEPTH:0]   cmd_len;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LOG_DEPTH-1:0] bram_addr;
  logic [WIDTH-1:0]     bram_rdata;
  logic [WIDTH-1:0]     ms_data;
  logic                 ms_valid;
  logic                 ms_ready;
  logic                 busy;
  logic                 done;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [5:0]       rdy_pat = 6'b101001;
  int               n_checks = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = WIDTH'(i);

  always @(posedge clk) bram_rdata <= mem[bram_addr];

  bram_stream_reader #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .ms_data    (ms_data),
    .ms_valid   (ms_valid),
    .ms_ready   (ms_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ms_ready always high; mode 1: fixed 1,0,0,1,0,1 then random
  task automatic run_cmd(input int unsigned addr, input int unsigned len,
                         input int unsigned mode);
    int unsigned      got, cyc, first_cyc, last_x, done_cyc, donecnt, post, pidx;
    logic             stalled, rdy;
    logic [WIDTH-1:0] held;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      step();
      cyc++;
    end
    check("cmd_ready_idle", WIDTH'(cmd_ready), WIDTH'(1));
    cmd_addr  = LOG_DEPTH'(addr);
    cmd_len   = (LOG_DEPTH + 1)'(len);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("busy_after_accept", WIDTH'(busy), WIDTH'(len != 0));

    got = 0; cyc = 0; first_cyc = NONE; last_x = 0; done_cyc = NONE;
    donecnt = 0; post = 0; pidx = 0; stalled = 1'b0; held = '0;
    while (cyc < 2000 && !(donecnt != 0 && post >= 3)) begin
      if (mode == 0)     rdy = 1'b1;
      else if (pidx < 6) rdy = rdy_pat[pidx];
      else               rdy = 1'($urandom_range(0, 1));
      pidx++;
      ms_ready = rdy;
      if (ms_valid && first_cyc == NONE) first_cyc = cyc;
      if (stalled) begin
        check("stall_valid", WIDTH'(ms_valid), WIDTH'(1));
        check("stall_data", ms_data, held);
      end
      if (ms_valid && rdy) begin
        if (got < len) check("word", ms_data, WIDTH'((addr + got) % DEPTH));
        got++;
        last_x = cyc;
      end
      stalled = ms_valid && !rdy;
      held    = ms_data;
      if (done) begin
        if (donecnt == 0) done_cyc = cyc;
        donecnt++;
      end
      if (donecnt != 0) post++;
      step();
      cyc++;
    end
    ms_ready = 1'b0;
    check("timeout", WIDTH'(cyc < 2000), WIDTH'(1));
    check("word_count", WIDTH'(got), WIDTH'(len));
    check("done_count", WIDTH'(donecnt), WIDTH'(1));
    check("done_cycle", WIDTH'(done_cyc), WIDTH'(len == 0 ? 0 : last_x + 1));
    if (len == 0) begin
      check("len0_no_valid", WIDTH'(first_cyc), WIDTH'(NONE));
    end else begin
      check("first_latency", WIDTH'(first_cyc), WIDTH'(2));
      if (mode == 0) check("no_bubbles", WIDTH'(last_x - first_cyc), WIDTH'(len - 1));
    end
    check("busy_end", WIDTH'(busy), WIDTH'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned got, cyc, spurious;
    resetn    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_valid = 1'b0;
    ms_ready  = 1'b0;
    repeat (3) step();
    check("rst_ms_valid", WIDTH'(ms_valid), WIDTH'(0));
    check("rst_busy", WIDTH'(busy), WIDTH'(0));
    check("rst_done", WIDTH'(done), WIDTH'(0));
    check("rst_cmd_ready", WIDTH'(cmd_ready), WIDTH'(0));
    check("rst_bram_addr", WIDTH'(bram_addr), WIDTH'(0));
    resetn = 1'b1;
    #1;
    check("cmd_ready_release", WIDTH'(cmd_ready), WIDTH'(1));

    run_cmd(10, 4, 0);
    run_cmd(510, 4, 0);
    run_cmd(0, 5, 1);
    run_cmd(0, 0, 0);
    run_cmd(0, 512, 0);
    run_cmd(300, 20, 1);

    // abort after two of eight words
    step();
    cmd_addr  = '0;
    cmd_len   = (LOG_DEPTH + 1)'(8);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    ms_ready  = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 20) begin
      if (ms_valid) begin
        check("pre_rst_word", ms_data, WIDTH'(got));
        got++;
      end
      step();
      cyc++;
    end
    check("pre_rst_count", WIDTH'(got), WIDTH'(2));
    resetn = 1'b0;
    step();
    check("abort_ms_valid", WIDTH'(ms_valid), WIDTH'(0));
    check("abort_busy", WIDTH'(busy), WIDTH'(0));
    check("abort_done", WIDTH'(done), WIDTH'(0));
    check("abort_cmd_ready", WIDTH'(cmd_ready), WIDTH'(0));
    check("abort_bram_addr", WIDTH'(bram_addr), WIDTH'(0));
    resetn   = 1'b1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      if (ms_valid || done) spurious++;
      step();
    end
    check("abort_quiet", WIDTH'(spurious), WIDTH'(0));
    ms_ready = 1'b0;

    run_cmd(0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
